prio_encoder_rr: RTL and testbench
==================================

Name: prio_encoder_rr

Overview:
- Parametrised N-to-log2(N) priority encoder with a registered output and a valid/ready handshake on both sides.
- Two selectable modes per transaction:
  - fixed priority, where the highest set index wins (legacy encoder semantics);
  - round-robin, using a rotating priority pointer.
- Sits between request sources (interrupt lines, arbiter requests) and downstream consumers that may stall.

Parameters:
- N, 8, number of request inputs; legal range 2..256.
- W, $clog2(N), index width; derived, must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_req  in  N  request vector; bit i is request i
- in_mode  in  1  0 = fixed priority, 1 = round-robin; sampled with in_req
- in_valid  in  1  in_req and in_mode are valid
- in_ready  out  1  block can accept a transaction this cycle
- out_idx  out  W  encoded winner index
- out_none  out  1  1 = no request bit set (equivalent of legacy valid=0)
- out_valid  out  1  out_idx/out_none are valid
- out_ready  in  1  downstream accepts output

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_idx=0, out_none=0, round-robin pointer ptr=N-1.
- in_ready = !out_valid || out_ready (combinational). This gives full throughput of one transaction per cycle.
- Accept: in_valid && in_ready. Results are registered, so latency is 1 cycle (accept in cycle t, out_valid=1 in cycle t+1).
- out_valid clears after an output handshake (out_valid && out_ready) when no new accept occurs in the same cycle. A simultaneous handshake and accept loads the new result and keeps out_valid=1.
- Hold rule: while out_valid && !out_ready, out_idx and out_none are stable, in_ready=0, and no input is lost.
- Fixed mode (in_mode=0): winner = highest set index. ptr is not modified.
- Round-robin mode (in_mode=1):
  - Search order: ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
  - Winner = first set bit in that order.
  - On accept with a nonzero request: ptr <= (winner==0) ? N-1 : winner-1.
- All-zero in_req, either mode: out_idx=0, out_none=1, ptr unchanged.
- Single set bit: both modes return the same index regardless of ptr.
- ptr wraps modulo N; it is updated only on accepted round-robin transactions.
- Reset asserted mid-operation: the pending output is discarded, out_valid=0 immediately (asynchronously), ptr=N-1.
- Inputs are ignored while in_valid=0. in_req may change freely when not accepted.

Optional Feature:
- Macro PRIO_ENC_ONEHOT_OUT_EN.
- Defined:
  - Adds output port out_onehot [N-1:0], registered with the same timing and hold rules as out_idx.
  - Bit out_idx is set; all zeros when out_none=1.
  - Reset value 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package prio_enc_pkg:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1;
  - function for ptr decrement-with-wrap.
- Sub-module prio_enc_core:
  - combinational N-input highest-index-first encoder producing idx and none;
  - round-robin is built by rotating in_req by ptr, encoding with prio_enc_core, then un-rotating the index (modulo N).

Test Plan:
- N=8, fixed mode, in_req=8'b0010_0110, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_none=0.
- Round-robin after reset, in_req=8'h81 sent on 4 consecutive cycles, out_ready=1 -> out_idx sequence 7,0,7,0 with one output per cycle.
- Round-robin, ptr=3 (reached by first accepting in_req=8'h10), then in_req=8'hFF -> out_idx=3; then in_req=8'h00 -> out_none=1, out_idx=0, ptr unchanged (next 8'hFF -> 2).
- Backpressure:
  - accept in_req=8'h08, hold out_ready=0 for 3 cycles while in_valid=1 with in_req=8'h40;
  - required: out_idx=3 stable, in_ready=0 throughout;
  - then out_ready=1 -> next output out_idx=6, nothing dropped.
- Mixed modes:
  - round-robin 8'h81 (-> 7), then fixed 8'h81 (-> 7), then round-robin 8'h81 (-> 0);
  - required: fixed-mode transactions do not move ptr.
- Reset mid-transaction: rst_n low while out_valid=1 -> out_valid=0 before the next clk edge; after release, round-robin 8'h81 -> 7 (ptr=N-1).

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the round-robin priority encoder:
// transaction mode encodings and the pointer decrement-with-wrap helper.
package prio_enc_pkg;

    // in_mode encodings, sampled together with in_req
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Step a round-robin pointer one position down, wrapping 0 -> n-1
    function automatic int ptr_dec(input int p, input int n);
        return (p == 0) ? n - 1 : p - 1;
    endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational N-input priority encoder: the highest set index wins.
// none=1 (and idx=0) when no request bit is set.
module prio_enc_core #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         none
);

    // Scan upward so the last (highest) set bit overrides earlier ones
    always_comb begin
        // NOTE: defaults assigned before the loop so every path drives both outputs and no latch is inferred.
        idx  = '0;
        none = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx  = W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Priority encoder with fixed or round-robin mode per transaction, a
// registered result and valid/ready handshakes on both sides.
// Round-robin searches ptr, ptr-1, ..., 0, N-1, ..., ptr+1 by rotating
// the request vector so that ptr lands on the top bit, reusing the
// highest-first core, then un-rotating the winning index.
// Optional: define PRIO_ENC_ONEHOT_OUT_EN to add a registered one-hot
// copy of the winner on out_onehot.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_req,
    input  logic         in_mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none,
    output logic         out_valid,
    input  logic         out_ready
`ifdef PRIO_ENC_ONEHOT_OUT_EN
    ,
    output logic [N-1:0] out_onehot
`endif
);

    logic [W-1:0] ptr;
    logic [N-1:0] rot_req;
    logic [W-1:0] fix_idx;
    logic         fix_none;
    logic [W-1:0] rot_idx;
    logic         rot_none;
    logic [W-1:0] rr_idx;
    logic [W-1:0] sel_idx;
    logic         sel_none;
    logic         accept;

    // A new transaction can enter whenever the output slot is empty or draining
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    prio_enc_core #(.N(N)) u_fix (
        .req  (in_req),
        .idx  (fix_idx),
        .none (fix_none)
    );

    // Rotate so rot_req[j] = in_req[(ptr+1+j) mod N]; ptr ends up on the top bit
    always_comb begin
        int k;
        k       = 0;
        rot_req = '0;
        for (int j = 0; j < N; j++) begin
            k = int'(ptr) + j + 1;
            if (k >= N) k = k - N;
            rot_req[j] = in_req[k[W-1:0]];
        end
    end

    prio_enc_core #(.N(N)) u_rot (
        .req  (rot_req),
        .idx  (rot_idx),
        .none (rot_none)
    );

    // Map the rotated winner back to its original request index (mod N)
    always_comb begin
        int s;
        s = int'(rot_idx) + int'(ptr) + 1;
        if (s >= N) s = s - N;
        rr_idx = s[W-1:0];
    end

    // Choose the result for the mode of the current transaction
    always_comb begin
        if (in_mode == MODE_RR) begin
            sel_none = rot_none;
            sel_idx  = rot_none ? '0 : rr_idx;
        end else begin
            sel_none = fix_none;
            sel_idx  = fix_idx;
        end
    end

    // Output register: load on accept, drop valid after an unreplaced handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_none  <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid <= 1'b1;
            out_idx   <= sel_idx;
            out_none  <= sel_none;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just below the winner of each accepted RR request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= W'(N - 1);
        end else if (accept && (in_mode == MODE_RR) && !rot_none) begin
            ptr <= W'(ptr_dec(int'(rr_idx), N));
        end
    end

`ifdef PRIO_ENC_ONEHOT_OUT_EN
    // One-hot copy of the winner, loaded and held exactly like out_idx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_onehot <= '0;
        end else if (accept) begin
            out_onehot <= sel_none ? '0 : (N'(1) << sel_idx);
        end
    end
`endif

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr (N=8): directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_prio_encoder_rr;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk;
    logic         rst_n;
    logic [N-1:0] in_req;
    logic         in_mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_idx;
    logic         out_none;
    logic         out_valid;
    logic         out_ready;
`ifdef PRIO_ENC_ONEHOT_OUT_EN
    logic [N-1:0] out_onehot;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: what the output register and pointer must hold
    bit m_valid;
    int m_idx;
    bit m_none;
    int m_ptr;

    prio_encoder_rr #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (in_req),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PRIO_ENC_ONEHOT_OUT_EN
        ,
        .out_onehot(out_onehot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner straight from the rules: scan positions in search order
    function automatic void ref_encode(input logic [N-1:0] r, input logic m, input int p,
                                       output int idx, output bit none);
        idx  = 0;
        none = 1'b1;
        for (int k = 0; k < N; k++) begin
            int q;
            q = m ? ((p - k + N) % N) : (N - 1 - k);
            if (r[q]) begin
                idx  = q;
                none = 1'b0;
                break;
            end
        end
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_none  = 1'b0;
        m_ptr   = N - 1;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    function automatic void model_update();
        int  w;
        bit  n;
        if (in_valid && (!m_valid || out_ready)) begin
            ref_encode(in_req, in_mode, m_ptr, w, n);
            m_valid = 1'b1;
            m_idx   = w;
            m_none  = n;
            if (in_mode && !n) m_ptr = (w == 0) ? N - 1 : w - 1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endfunction

    // Apply inputs, take one clock edge, land 1 time unit after it
    task automatic step(input logic [N-1:0] r, input logic m, input logic v, input logic o);
        in_req    = r;
        in_mode   = m;
        in_valid  = v;
        out_ready = o;
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    // Compare DUT against the model on every falling edge out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("out_idx", 32'(out_idx), 32'(m_idx));
                check("out_none", 32'(out_none), 32'(m_none));
`ifdef PRIO_ENC_ONEHOT_OUT_EN
                check("out_onehot", 32'(out_onehot), m_none ? 32'd0 : (32'd1 << m_idx));
`endif
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        rst_n     = 1'b0;
        in_req    = '0;
        in_mode   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_idx", 32'(out_idx), 32'd0);
        check("rst out_none", 32'(out_none), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
`ifdef PRIO_ENC_ONEHOT_OUT_EN
        check("rst out_onehot", 32'(out_onehot), 32'd0);
`endif
        rst_n = 1'b1;

        // Fixed priority: highest set bit of 0010_0110
        step(8'b0010_0110, 1'b0, 1'b1, 1'b1);
        check("fixed valid", 32'(out_valid), 32'd1);
        check("fixed idx", 32'(out_idx), 32'd5);
        check("fixed none", 32'(out_none), 32'd0);

        // Round-robin from reset pointer: 81 alternates 7,0,7,0
        step(8'h81, 1'b1, 1'b1, 1'b1);
        check("rr81 #1", 32'(out_idx), 32'd7);
        step(8'h81, 1'b1, 1'b1, 1'b1);
        check("rr81 #2", 32'(out_idx), 32'd0);
        step(8'h81, 1'b1, 1'b1, 1'b1);
        check("rr81 #3", 32'(out_idx), 32'd7);
        step(8'h81, 1'b1, 1'b1, 1'b1);
        check("rr81 #4", 32'(out_idx), 32'd0);
        check("rr81 valid", 32'(out_valid), 32'd1);

        // Pointer to 3 via request 4, then full vector, then empty
        step(8'h10, 1'b1, 1'b1, 1'b1);
        check("rr10 idx", 32'(out_idx), 32'd4);
        step(8'hFF, 1'b1, 1'b1, 1'b1);
        check("rrFF ptr3", 32'(out_idx), 32'd3);
        step(8'h00, 1'b1, 1'b1, 1'b1);
        check("rr00 none", 32'(out_none), 32'd1);
        check("rr00 idx", 32'(out_idx), 32'd0);
        step(8'hFF, 1'b1, 1'b1, 1'b1);
        check("rrFF ptr2", 32'(out_idx), 32'd2);

        // Backpressure: result 3 held while a second request waits
        step(8'h08, 1'b0, 1'b1, 1'b1);
        check("bp first", 32'(out_idx), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(8'h40, 1'b0, 1'b1, 1'b0);
            check("bp hold idx", 32'(out_idx), 32'd3);
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        step(8'h40, 1'b0, 1'b1, 1'b1);
        check("bp next", 32'(out_idx), 32'd6);
        check("bp next valid", 32'(out_valid), 32'd1);

        // Stalled pending output, then reset mid-transaction
        step(8'h81, 1'b1, 1'b1, 1'b0);
        check("pre-rst valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async rst valid", 32'(out_valid), 32'd0);
        check("async rst idx", 32'(out_idx), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Mixed modes after reset: fixed transactions leave the pointer alone
        step(8'h81, 1'b1, 1'b1, 1'b1);
        check("mix rr #1", 32'(out_idx), 32'd7);
        step(8'h81, 1'b0, 1'b1, 1'b1);
        check("mix fixed", 32'(out_idx), 32'd7);
        step(8'h81, 1'b1, 1'b1, 1'b1);
        check("mix rr #2", 32'(out_idx), 32'd0);

        // Randomized traffic; the falling-edge compare does the checking
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = N'(1) << $urandom_range(0, N - 1);
                2:       r = N'($urandom);
                default: r = N'($urandom & $urandom);
            endcase
            step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        step('0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
